// File: rtl/if_pkg.sv
// if_pkg -- shared types for the instruction-fetch prefetch stage.
//   pc_mux_e      : redirect source select
//   fetch_entry_t : one prefetch-buffer entry {pc, instr}
//   if_state_e    : fetch FSM state
package if_pkg;

  typedef enum logic [1:0] {
    PC_INCR   = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_BOOT   = 2'b11
  } pc_mux_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HALT  = 2'b10
  } if_state_e;

endpackage

// File: rtl/if_prefetch_fifo.sv
// if_prefetch_fifo -- registered prefetch buffer (no bypass).
//   clk_i, rstn_i : clock, async active-low reset
//   flush_i       : drop all entries (wins over push/pop)
//   push_i/data_i : write entry; accepted when not full or when popping
//   pop_i         : consume head entry
//   data_o        : head entry, zero when empty
//   empty_o/full_o/count_o : occupancy status
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [AW:0]     cnt_q;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  // Full + pop in the same cycle frees the slot being written.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/if_stage_prefetch.sv
// if_stage_prefetch -- IF stage with in-order prefetch buffer.
//   clk_i, rstn_i        : clock, async active-low reset
//   instr_req_o/addr_o   : fetch request, word-aligned address
//   instr_gnt_i          : request accepted
//   instr_rvalid_i/rdata_i : in-order response
//   pc_set_i, pc_mux_i   : redirect strobe and source
//   jump_target_i, branch_target_i : redirect targets
//   id_ready_i           : ID consumes head entry
//   instr_valid_id_o, instr_rdata_id_o, pc_if_o : head entry to ID
//   instr_misaligned_o   : redirect target was not word-aligned
// Build option: define IF_ALIGN_CHECK_EN to flag misaligned redirect
// targets and halt fetching; otherwise targets are silently aligned.
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        pc_set_i,
  input  logic [1:0]  pc_mux_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] pc_if_o,
  output logic        instr_misaligned_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_addr_q;
  logic [31:0]   rsp_pc_q;       // PC of the next response that will be kept
  logic [CW-1:0] out_cnt_q, out_nxt;
  logic [CW-1:0] disc_cnt_q;
  logic [CW-1:0] fifo_cnt, credit;
  logic          fifo_empty, fifo_full;
  fetch_entry_t  head, push_entry;
  logic          req, gnt_acc, rv, push, pop, fetch_ok;
  logic [31:0]   tgt_raw, tgt;
  logic          misal_tgt;

  // ---------------- redirect target ----------------
  always_comb begin
    tgt_raw = BOOT_ADDR;
    case (pc_mux_e'(pc_mux_i))
      PC_INCR:   tgt_raw = fifo_empty ? fetch_addr_q : head.pc + 32'd4;
      PC_JUMP:   tgt_raw = jump_target_i;
      PC_BRANCH: tgt_raw = branch_target_i;
      default:   tgt_raw = BOOT_ADDR;
    endcase
  end

  assign tgt = tgt_raw & ~32'h3;
`ifdef IF_ALIGN_CHECK_EN
  assign misal_tgt = (tgt_raw[1:0] != 2'b00);
`else
  assign misal_tgt = 1'b0;
`endif

  // ---------------- request / response bookkeeping ----------------
  assign pop = !fifo_empty && id_ready_i;
  // A head leaving this cycle frees its slot, so back-to-back fetch
  // sustains one instruction per cycle even at depth 2.
  assign credit   = out_cnt_q + fifo_cnt - CW'(pop);
  assign fetch_ok = (credit < DEPTH_C) && (!fifo_full || pop);

  assign gnt_acc = req && instr_gnt_i;
  // Responses with nothing outstanding (stale after reset) are ignored.
  assign rv      = instr_rvalid_i && (out_cnt_q != '0);
  assign out_nxt = out_cnt_q + CW'(gnt_acc) - CW'(rv);
  assign push    = rv && (disc_cnt_q == '0) && !pc_set_i;

  assign push_entry.pc    = rsp_pc_q;
  assign push_entry.instr = instr_rdata_i;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: req = fetch_ok;
      S_HALT:  req = 1'b0;
      default: state_d = S_IDLE;
    endcase
    if (pc_set_i) state_d = misal_tgt ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= BOOT_ADDR;
      rsp_pc_q     <= BOOT_ADDR;
      out_cnt_q    <= '0;
      disc_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_nxt;
      if (pc_set_i) begin
        fetch_addr_q <= tgt;
        rsp_pc_q     <= tgt;
        // Everything still in flight (incl. a same-cycle grant) is stale.
        disc_cnt_q   <= out_nxt;
      end else begin
        if (gnt_acc) fetch_addr_q <= fetch_addr_q + 32'd4;
        if (push)    rsp_pc_q     <= rsp_pc_q + 32'd4;
        if (rv && disc_cnt_q != '0) disc_cnt_q <= disc_cnt_q - 1'b1;
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic misal_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       misal_q <= 1'b0;
    else if (pc_set_i) misal_q <= misal_tgt;
  end
  assign instr_misaligned_o = misal_q;
`else
  assign instr_misaligned_o = 1'b0;
`endif

  // ---------------- prefetch buffer ----------------
  if_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (pc_set_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign instr_req_o      = req;
  assign instr_addr_o     = fetch_addr_q;
  assign instr_valid_id_o = !fifo_empty;
  assign instr_rdata_id_o = head.instr;
  assign pc_if_o          = head.pc;

endmodule

// File: tb/tb_if_stage_prefetch.sv
// tb_if_stage_prefetch -- directed bench for if_stage_prefetch (depth 2).
// Memory model grants while gnt is high and answers in order one cycle
// after grant while rsp_en is set; data is address ^ constant.
module tb_if_stage_prefetch;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        req, gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] addr, rdata = '0;
  logic        pc_set = 1'b0;
  logic [1:0]  pc_mux = 2'b00;
  logic [31:0] jtgt = '0, btgt = '0;
  logic        id_ready = 1'b0;
  logic        vld, misal;
  logic [31:0] rdata_id, pc_if;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  if_stage_prefetch #(.BOOT_ADDR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .pc_set_i(pc_set), .pc_mux_i(pc_mux),
    .jump_target_i(jtgt), .branch_target_i(btgt),
    .id_ready_i(id_ready), .instr_valid_id_o(vld),
    .instr_rdata_id_o(rdata_id), .pc_if_o(pc_if),
    .instr_misaligned_o(misal)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  logic [31:0] q[$];
  bit rsp_en = 1'b1, mem_flush = 1'b0;

  always @(posedge clk) begin
    rvalid <= 1'b0;
    if (mem_flush) q.delete();
    else begin
      if (rstn && req && gnt) q.push_back(addr);
      if (rsp_en && q.size() > 0) begin
        rvalid <= 1'b1;
        rdata  <= data_of(q[0]);
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!vld && n < 20) begin tick(); n++; end
    if (!vld) chk({tag, "_timeout"}, 32'(vld), 32'd1);
  endtask

  task automatic wait_req_low(input string tag);
    int n = 0;
    tick();
    while (req && n < 20) begin tick(); n++; end
    if (req) chk({tag, "_timeout"}, 32'(req), 32'd0);
  endtask

  task automatic reset_dut();
    rstn = 1'b0; pc_set = 1'b0; mem_flush = 1'b1;
    tick(); tick();
    mem_flush = 1'b0;
  endtask

  task automatic redirect(input logic [1:0] m, input logic [31:0] t);
    pc_set = 1'b1; pc_mux = m; jtgt = t; btgt = t;
    tick();
    pc_set = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int ng, nv;

    // ---- reset state ----
    tick(); tick();
    chk("rst_req",   32'(req), 32'd0);
    chk("rst_addr",  addr,     32'h0);
    chk("rst_vld",   32'(vld), 32'd0);
    chk("rst_rdata", rdata_id, 32'h0);
    chk("rst_pc",    pc_if,    32'h0);
    chk("rst_misal", 32'(misal), 32'd0);

    // ---- streaming: one PC per cycle ----
    reset_dut();
    gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b1; rstn = 1'b1; #1;
    wait_valid("stream");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_pc%0d", i), pc_if, 32'(4 * i));
      chk($sformatf("stream_d%0d", i), rdata_id, data_of(32'(4 * i)));
      tick();
    end
    // redirect while a grant and a response share the cycle
    redirect(2'b01, 32'h0000_4000);
    chk("rgnt_vld",  32'(vld), 32'd0);
    chk("rgnt_addr", addr, 32'h0000_4000);
    wait_valid("rgnt");
    chk("rgnt_pc", pc_if, 32'h0000_4000);
    chk("rgnt_d",  rdata_id, data_of(32'h0000_4000));

    // ---- backpressure: exactly two grants ----
    reset_dut();
    gnt = 1'b1; id_ready = 1'b0; rsp_en = 1'b1; rstn = 1'b1; #1;
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      if (req && gnt) ng++;
      tick();
    end
    chk("bp_grants", 32'(ng), 32'd2);
    chk("bp_req",    32'(req), 32'd0);
    chk("bp_pc",     pc_if, 32'h0);
    id_ready = 1'b1; #1;
    chk("bp_resume", 32'(req), 32'd1);
    tick();
    id_ready = 1'b0; #1;
    chk("bp_head", pc_if, 32'h4);
    redirect(2'b00, 32'h0);                 // PC_INCR: head 4 -> 8
    chk("incr_addr", addr, 32'h8);
    chk("incr_vld",  32'(vld), 32'd0);
    redirect(2'b11, 32'h0);                 // PC_BOOT
    chk("boot_addr", addr, 32'h0);

    // ---- two outstanding, jump drops both responses ----
    reset_dut();
    gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b0; rstn = 1'b1; #1;
    wait_req_low("jmp");
    redirect(2'b01, 32'h0000_1000);
    chk("jmp_addr", addr, 32'h0000_1000);
    chk("jmp_vld",  32'(vld), 32'd0);
    rsp_en = 1'b1;
    wait_valid("jmp");
    chk("jmp_pc", pc_if, 32'h0000_1000);
    chk("jmp_d",  rdata_id, data_of(32'h0000_1000));

    // ---- reset mid-transaction, late responses ignored ----
    reset_dut();
    gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b0; rstn = 1'b1; #1;
    wait_req_low("mrst");
    rstn = 1'b0; gnt = 1'b0; #1;
    chk("mrst_req",  32'(req), 32'd0);
    chk("mrst_addr", addr, 32'h0);
    tick();
    rstn = 1'b1; rsp_en = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (vld) nv++; end
    chk("mrst_stale", 32'(nv), 32'd0);
    gnt = 1'b1;
    wait_valid("mrst");
    chk("mrst_pc", pc_if, 32'h0);
    chk("mrst_d",  rdata_id, data_of(32'h0));

    // ---- stall: address stable, redirect in cycle 3 ----
    reset_dut();
    gnt = 1'b0; id_ready = 1'b1; rsp_en = 1'b1; rstn = 1'b1; #1;
    tick(); tick();
    chk("stall_req", 32'(req), 32'd1);
    chk("stall_a1", addr, 32'h0); tick();
    chk("stall_a2", addr, 32'h0); tick();
    chk("stall_a3", addr, 32'h0);
    redirect(2'b10, 32'h0000_2000);
    chk("stall_a4", addr, 32'h0000_2000);
    chk("stall_r4", 32'(req), 32'd1);
    tick();
    chk("stall_a5", addr, 32'h0000_2000);

    // ---- address wrap ----
    redirect(2'b01, 32'hFFFF_FFFC);
    chk("wrap_a0", addr, 32'hFFFF_FFFC);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("wrap_a1", addr, 32'h0);
    wait_valid("wrap");
    chk("wrap_pc", pc_if, 32'hFFFF_FFFC);
    chk("wrap_d",  rdata_id, data_of(32'hFFFF_FFFC));

    // ---- misaligned redirect ----
    redirect(2'b10, 32'h0000_0102);
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_flag", 32'(misal), 32'd1);
    chk("mis_req",  32'(req), 32'd0);
    gnt = 1'b1;
    tick(); tick(); tick();
    chk("mis_hold_req",  32'(req), 32'd0);
    chk("mis_hold_flag", 32'(misal), 32'd1);
    redirect(2'b01, 32'h0000_3000);
    chk("mis_clr",  32'(misal), 32'd0);
    chk("mis_addr", addr, 32'h0000_3000);
    chk("mis_req1", 32'(req), 32'd1);
`else
    chk("mis_flag", 32'(misal), 32'd0);
    chk("mis_addr", addr, 32'h0000_0100);
    chk("mis_req",  32'(req), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage_prefetch.md
IF_STAGE_PREFETCH -- requirements
Module: if_stage_prefetch

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset and target of PC_BOOT.
REQ-002 Parameter FIFO_DEPTH, default 2, prefetch-buffer entries and outstanding-request limit; power of two, range 2..16.
REQ-003 clk_i  in  1  the single clock, rising edge.
REQ-004 rstn_i  in  1  asynchronous active-low reset.
REQ-005 instr_req_o  out  1  fetch request to instruction memory.
REQ-006 instr_addr_o  out  32  word-aligned fetch address.
REQ-007 instr_gnt_i  in  1  request accepted this cycle.
REQ-008 instr_rvalid_i  in  1  read data valid; responses arrive in order, at least one cycle after grant.
REQ-009 instr_rdata_i  in  32  fetched instruction word.
REQ-010 pc_set_i  in  1  redirect strobe, qualifies pc_mux_i.
REQ-011 pc_mux_i  in  2  redirect source: 00 PC_INCR, 01 PC_JUMP, 10 PC_BRANCH, 11 PC_BOOT.
REQ-012 jump_target_i / branch_target_i  in  32 each  redirect targets.
REQ-013 id_ready_i  in  1  ID stage consumes head entry.
REQ-014 instr_valid_id_o  out  1  head entry valid.
REQ-015 instr_rdata_id_o / pc_if_o  out  32 each  head instruction and its PC.
REQ-016 instr_misaligned_o  out  1  redirect target not word-aligned.

Function
REQ-017 FSM states IDLE, FETCH, HALT; IDLE->FETCH one cycle after reset release; FETCH->HALT on misaligned redirect; HALT->FETCH on aligned redirect.
REQ-018 In FETCH, instr_req_o SHALL assert when outstanding + FIFO occupancy < FIFO_DEPTH.
REQ-019 instr_addr_o SHALL hold stable while instr_req_o is high without grant, except on redirect.
REQ-020 On grant, fetch address += 4 (mod 2^32, wraps 32'hFFFF_FFFC->0) and outstanding += 1.
REQ-021 On rvalid, {address, rdata} SHALL be pushed into the FIFO unless discard count > 0, in which case the response is dropped and the discard count decremented.
REQ-022 instr_valid_id_o = FIFO non-empty; head popped when instr_valid_id_o & id_ready_i; push and pop in the same cycle legal, including when full.
REQ-023 Latency: rvalid in cycle N -> instr_valid_id_o in cycle N+1 (registered FIFO, no bypass).
REQ-024 pc_set_i in cycle N: FIFO flushed, instr_valid_id_o low in N+1, discard count := outstanding, fetch address := selected target, new request issued from N+1.
REQ-025 PC_INCR redirect target = head PC + 4 (FIFO empty: current fetch address).
REQ-026 Redirect with same-cycle grant: the granted request is added to the discard count; redirect with same-cycle rvalid: response dropped.
REQ-027 An ungranted request at redirect is withdrawn; the retargeted address is presented from N+1.

Reset
REQ-028 During reset: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_id_o=0, instr_rdata_id_o=0, pc_if_o=0, instr_misaligned_o=0, FIFO empty, counters 0, state IDLE.
REQ-029 Reset mid-transaction SHALL abandon all outstanding requests; late rvalid after reset release with zero outstanding SHALL be ignored.

Configuration
REQ-030 Macro IF_ALIGN_CHECK_EN defined: redirect target[1:0]!=0 sets instr_misaligned_o (sticky until next redirect), enters HALT, no requests issued.
REQ-031 Macro absent: instr_misaligned_o tied 0, HALT unreachable, target[1:0] forced to 00.

Structure
REQ-032 Package if_pkg SHALL hold the pc_mux_e enum, fetch_entry_t struct {pc, instr} and the FSM state enum.
REQ-033 Sub-module if_prefetch_fifo (parametrised depth, flush, push/pop, full/empty) SHALL hold the buffer.

Verification
REQ-034 Reset release, gnt=1 every cycle, rvalid one cycle after gnt, id_ready=1 -> PCs 0,4,8,... one per cycle on pc_if_o.
REQ-035 id_ready=0, FIFO_DEPTH=2 -> exactly 2 grants then instr_req_o=0; id_ready=1 resumes requests next cycle.
REQ-036 Two outstanding, jump to 32'h0000_1000 -> both old rvalids dropped, first valid entry pc_if_o=32'h1000.
REQ-037 gnt held 0 for 5 cycles -> instr_addr_o constant; redirect in cycle 3 -> address becomes target in cycle 4.
REQ-038 IF_ALIGN_CHECK_EN, branch to 32'h0000_0102 -> instr_misaligned_o=1, no further requests until aligned redirect.
REQ-039 Fetch across 32'hFFFF_FFFC -> next address 32'h0000_0000.
